// File: rtl/spi_adc_responder.sv
// SPI slave that mimics a 2-channel 10-bit ADC (MCP3002-style command frame).
// All SPI pins are resynchronized into sysclk and acted on at detected edges.
module spi_adc_responder (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [9:0] sample_ch0,
  input  logic [9:0] sample_ch1,
  input  logic       adc_cs,
  input  logic       adc_sck,
  input  logic       sdata_to_adc,
  output logic       sdata_from_adc,
  output logic       channel_sel,
  output logic       frame_done,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_CFG, S_NULL, S_DATA, S_LSBF, S_TAIL
  } state_t;

  state_t     r_state, w_state_nxt;

  logic       r_cs_s1, r_cs_s2, r_cs_d;
  logic       r_sck_s1, r_sck_s2, r_sck_d;
  logic       r_din_s1, r_din_s2;
  logic [1:0] r_init;
  logic       r_arm;

  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_sgl, w_sgl_nxt;
  logic       r_odd, w_odd_nxt;
  logic       r_msbf, w_msbf_nxt;
  logic [9:0] r_res, w_res_nxt;
  logic       r_dout, w_dout_nxt;
  logic       r_chsel, w_chsel_nxt;
  logic       r_started, w_started_nxt;
  logic       r_b0, w_b0_nxt;
  logic       r_done, w_done_nxt;
  logic       r_err, w_err_nxt;

  logic       w_cs_fall, w_cs_rise;
  logic       w_sck_rise, w_sck_fall;
  logic [9:0] w_d01, w_d10, w_pick;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_s1  <= 1'b1;
      r_cs_s2  <= 1'b1;
      r_cs_d   <= 1'b1;
      r_sck_s1 <= 1'b0;
      r_sck_s2 <= 1'b0;
      r_sck_d  <= 1'b0;
      r_din_s1 <= 1'b0;
      r_din_s2 <= 1'b0;
      r_init   <= 2'b00;
      r_arm    <= 1'b0;
    end else begin
      r_cs_s1  <= adc_cs;
      r_cs_s2  <= r_cs_s1;
      r_cs_d   <= r_cs_s2;
      r_sck_s1 <= adc_sck;
      r_sck_s2 <= r_sck_s1;
      r_sck_d  <= r_sck_s2;
      r_din_s1 <= sdata_to_adc;
      r_din_s2 <= r_din_s1;
      r_init   <= {r_init[0], 1'b1};
      r_arm    <= r_arm | (r_init[1] & r_cs_s2);
    end
  end

  // A CS low held through reset is not a frame start: arm only after real CS high.
  assign w_cs_fall  = r_arm & r_cs_d & ~r_cs_s2;
  assign w_cs_rise  = ~r_cs_d & r_cs_s2;
  assign w_sck_rise = ~r_sck_d & r_sck_s2;
  assign w_sck_fall = r_sck_d & ~r_sck_s2;

  assign w_d01 = (sample_ch0 > sample_ch1) ?
                 (sample_ch0 - sample_ch1) : 10'd0;
  assign w_d10 = (sample_ch1 > sample_ch0) ?
                 (sample_ch1 - sample_ch0) : 10'd0;
  assign w_pick = r_sgl ?
                  (r_odd ? sample_ch1 : sample_ch0) :
                  (r_odd ? w_d10 : w_d01);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_rise) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_cs_fall) w_state_nxt = S_WAIT;
        S_WAIT: if (w_sck_rise && r_din_s2) w_state_nxt = S_CFG;
        S_CFG:  if (w_sck_rise && r_cnt == 4'd2) w_state_nxt = S_NULL;
        S_NULL: if (w_sck_fall) w_state_nxt = S_DATA;
        S_DATA: if (w_sck_fall && r_cnt == 4'd0)
                  w_state_nxt = r_msbf ? S_TAIL : S_LSBF;
        S_LSBF: if (w_sck_fall && r_cnt == 4'd9) w_state_nxt = S_TAIL;
        S_TAIL: w_state_nxt = S_TAIL;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_sgl_nxt     = r_sgl;
    w_odd_nxt     = r_odd;
    w_msbf_nxt    = r_msbf;
    w_res_nxt     = r_res;
    w_dout_nxt    = r_dout;
    w_chsel_nxt   = r_chsel;
    w_started_nxt = r_started;
    w_b0_nxt      = r_b0;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    if (w_cs_rise) begin
      w_dout_nxt    = 1'b0;
      w_done_nxt    = r_b0;
      w_err_nxt     = r_started & ~r_b0;
      w_started_nxt = 1'b0;
      w_b0_nxt      = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: w_dout_nxt = 1'b0;
        S_WAIT: begin
          w_dout_nxt = 1'b0;
          if (w_sck_rise && r_din_s2) begin
            w_started_nxt = 1'b1;
            w_cnt_nxt     = 4'd0;
          end
        end
        S_CFG: begin
          w_dout_nxt = 1'b0;
          if (w_sck_rise) begin
            w_cnt_nxt = r_cnt + 4'd1;
            if (r_cnt == 4'd0) begin
              w_sgl_nxt = r_din_s2;
            end else if (r_cnt == 4'd1) begin
              w_odd_nxt = r_din_s2;
            end else begin
              w_msbf_nxt  = r_din_s2;
              w_res_nxt   = w_pick;
              w_chsel_nxt = r_odd;
            end
          end
        end
        S_NULL: begin
          if (w_sck_fall) begin
            w_dout_nxt = 1'b0;
            w_cnt_nxt  = 4'd9;
          end
        end
        S_DATA: begin
          if (w_sck_fall) begin
            w_dout_nxt = r_res[r_cnt];
            if (r_cnt == 4'd0) begin
              w_b0_nxt  = 1'b1;
              w_cnt_nxt = 4'd1;
            end else begin
              w_cnt_nxt = r_cnt - 4'd1;
            end
          end
        end
        S_LSBF: begin
          if (w_sck_fall) begin
            w_dout_nxt = r_res[r_cnt];
            w_cnt_nxt  = r_cnt + 4'd1;
          end
        end
        S_TAIL: if (w_sck_fall) w_dout_nxt = 1'b0;
        default: w_dout_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 4'd0;
      r_sgl     <= 1'b0;
      r_odd     <= 1'b0;
      r_msbf    <= 1'b0;
      r_res     <= 10'd0;
      r_dout    <= 1'b0;
      r_chsel   <= 1'b0;
      r_started <= 1'b0;
      r_b0      <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_sgl     <= w_sgl_nxt;
      r_odd     <= w_odd_nxt;
      r_msbf    <= w_msbf_nxt;
      r_res     <= w_res_nxt;
      r_dout    <= w_dout_nxt;
      r_chsel   <= w_chsel_nxt;
      r_started <= w_started_nxt;
      r_b0      <= w_b0_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign sdata_from_adc = r_dout;
  assign channel_sel    = r_chsel;
  assign frame_done     = r_done;
  assign frame_err      = r_err;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: SPI master model with
// hand-computed DOUT streams and frame pulse counts.
module tb_spi_adc_responder;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic [9:0] sample_ch0, sample_ch1;
  logic       adc_cs, adc_sck, sdata_to_adc;
  logic       sdata_from_adc, channel_sel;
  logic       frame_done, frame_err;

  int n_chk = 0;
  int n_errors = 0;
  int n_done = 0;
  int n_ferr = 0;

  spi_adc_responder dut (
    .sysclk         (sysclk),
    .rst_n          (rst_n),
    .sample_ch0     (sample_ch0),
    .sample_ch1     (sample_ch1),
    .adc_cs         (adc_cs),
    .adc_sck        (adc_sck),
    .sdata_to_adc   (sdata_to_adc),
    .sdata_from_adc (sdata_from_adc),
    .channel_sel    (channel_sel),
    .frame_done     (frame_done),
    .frame_err      (frame_err)
  );

  always #10 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    if (frame_done) n_done <= n_done + 1;
    if (frame_err)  n_ferr <= n_ferr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // One SCK period: DIN set in the low phase, DOUT sampled just before rise.
  task automatic sck_bit(input logic d, output logic q);
    sdata_to_adc = d;
    wait_clk(8);
    q = sdata_from_adc;
    adc_sck = 1'b1;
    wait_clk(8);
    adc_sck = 1'b0;
  endtask

  task automatic send_cmd(input int nz, input logic s, input logic o,
                          input logic m);
    logic q;
    for (int i = 0; i < nz; i++) sck_bit(1'b0, q);
    sck_bit(1'b1, q);
    sck_bit(s, q);
    sck_bit(o, q);
    sck_bit(m, q);
  endtask

  task automatic read_bits(input int n, output logic [31:0] bits);
    logic q;
    bits = '0;
    for (int i = 0; i < n; i++) begin
      sck_bit(1'b0, q);
      bits = {bits[30:0], q};
    end
  endtask

  task automatic run_frame(input int nz, input logic s, input logic o,
                           input logic m, input int nrd,
                           output logic [31:0] bits);
    @(negedge sysclk);
    adc_cs = 1'b0;
    wait_clk(8);
    send_cmd(nz, s, o, m);
    read_bits(nrd, bits);
    wait_clk(8);
    adc_cs = 1'b1;
    wait_clk(12);
  endtask

  initial begin
    logic [31:0] bits;
    int d0, e0;
    rst_n = 1'b0;
    adc_cs = 1'b1;
    adc_sck = 1'b0;
    sdata_to_adc = 1'b0;
    sample_ch0 = 10'h2A5;
    sample_ch1 = 10'h0F0;
    wait_clk(3);
    chk("reset_outs", {sdata_from_adc, channel_sel, frame_done, frame_err}, 0);
    rst_n = 1'b1;
    wait_clk(6);

    d0 = n_done; e0 = n_ferr;
    run_frame(0, 1'b1, 1'b0, 1'b1, 11, bits);
    chk("ch0_msbf_dout", bits, 32'h2A5);
    chk("ch0_msbf_sel", channel_sel, 0);
    chk("ch0_msbf_done", n_done - d0, 1);
    chk("ch0_msbf_err", n_ferr - e0, 0);
    chk("ch0_msbf_idle", sdata_from_adc, 0);

    d0 = n_done; e0 = n_ferr;
    run_frame(0, 1'b1, 1'b1, 1'b0, 20, bits);
    chk("ch1_lsbf_dout", bits, 32'h1E03C);
    chk("ch1_lsbf_sel", channel_sel, 1);
    chk("ch1_lsbf_done", n_done - d0, 1);
    chk("ch1_lsbf_err", n_ferr - e0, 0);

    d0 = n_done; e0 = n_ferr;
    run_frame(2, 1'b1, 1'b0, 1'b1, 11, bits);
    chk("lead0_dout", bits, 32'h2A5);
    chk("lead0_sel", channel_sel, 0);
    chk("lead0_done", n_done - d0, 1);

    sample_ch0 = 10'h100;
    sample_ch1 = 10'h180;
    run_frame(0, 1'b0, 1'b0, 1'b1, 11, bits);
    chk("diff01_sat", bits, 32'h000);
    chk("diff01_sel", channel_sel, 0);
    run_frame(0, 1'b0, 1'b1, 1'b1, 11, bits);
    chk("diff10_dout", bits, 32'h080);
    chk("diff10_sel", channel_sel, 1);

    sample_ch0 = 10'h2A5;
    sample_ch1 = 10'h0F0;
    d0 = n_done; e0 = n_ferr;
    run_frame(0, 1'b1, 1'b0, 1'b1, 6, bits);
    chk("abort_bits", bits, 32'h15);
    chk("abort_err", n_ferr - e0, 1);
    chk("abort_done", n_done - d0, 0);
    chk("abort_dout", sdata_from_adc, 0);
    run_frame(0, 1'b1, 1'b1, 1'b1, 11, bits);
    chk("after_abort_dout", bits, 32'h0F0);
    chk("after_abort_sel", channel_sel, 1);

    // Reset in the middle of the data phase, CS still low afterwards.
    d0 = n_done; e0 = n_ferr;
    @(negedge sysclk);
    adc_cs = 1'b0;
    wait_clk(8);
    send_cmd(0, 1'b1, 1'b1, 1'b1);
    read_bits(4, bits);
    chk("pre_rst_bits", bits, 32'h1);
    wait_clk(2);
    rst_n = 1'b0;
    #1;
    chk("rst_outs", {sdata_from_adc, channel_sel, frame_done, frame_err}, 0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    send_cmd(0, 1'b1, 1'b1, 1'b1);
    read_bits(11, bits);
    chk("cs_low_after_rst", bits, 0);
    chk("cs_low_after_rst_sel", channel_sel, 0);
    adc_cs = 1'b1;
    wait_clk(12);
    chk("rst_no_done", n_done - d0, 0);
    chk("rst_no_err", n_ferr - e0, 0);
    d0 = n_done;
    run_frame(0, 1'b1, 1'b0, 1'b1, 11, bits);
    chk("post_rst_dout", bits, 32'h2A5);
    chk("post_rst_done", n_done - d0, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_errors);
    $finish;
  end

endmodule
